// File: rtl/rrf_freelist.sv
// ---------------------------------------------------------------------------
// rrf_freelist
//   Circular free-list allocator for rename/reorder (RRF) entries. Dispatch
//   takes up to two consecutive entries per cycle from dp_ptr. Commit
//   returns up to two of the oldest entries per cycle from com_ptr. A flush
//   discards every uncommitted entry by moving dp_ptr back to the commit
//   point.
//
// Ports
//   clk            clock; all state changes on its rising edge
//   rst_n          synchronous active-low reset
//   i_req_num      entries dispatch asks for this cycle (0..2)
//   i_stall_ext    stall raised by other dispatch resources
//   i_com_num      entries commit retires this cycle (0..2)
//   i_flush        mispredict recovery
//   o_alloc_ptr_1  entry granted to dispatch slot 1
//   o_alloc_ptr_2  entry granted to dispatch slot 2
//   o_stall        dispatch stall; nothing is allocated this cycle
//   o_com_ptr      oldest uncommitted entry
//   o_free_num     number of free entries (0..RRF_ENT_NUM)
//   o_full         no free entries
//   o_empty        every entry is free
// ---------------------------------------------------------------------------
module rrf_freelist #(
  parameter int RRF_ENT_NUM = 64,
  parameter int RRF_ENT_SEL = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_req_num,
  input  logic                   i_stall_ext,
  input  logic [1:0]             i_com_num,
  input  logic                   i_flush,
  output logic [RRF_ENT_SEL-1:0] o_alloc_ptr_1,
  output logic [RRF_ENT_SEL-1:0] o_alloc_ptr_2,
  output logic                   o_stall,
  output logic [RRF_ENT_SEL-1:0] o_com_ptr,
  output logic [RRF_ENT_SEL:0]   o_free_num,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam logic [RRF_ENT_SEL:0] LP_ALL_FREE = (RRF_ENT_SEL+1)'(RRF_ENT_NUM);

  logic [RRF_ENT_SEL-1:0] r_dp_ptr;
  logic [RRF_ENT_SEL-1:0] r_com_ptr;
  logic [RRF_ENT_SEL:0]   r_free_cnt;

  logic [RRF_ENT_SEL:0]   w_req_cnt;
  logic [1:0]             w_alloc_num;
  logic [RRF_ENT_SEL-1:0] w_com_ptr_next;
  logic                   w_stall;

  // Request widened to the counter width for the free-space compare.
  assign w_req_cnt = {{(RRF_ENT_SEL-1){1'b0}}, i_req_num};

  // Entries retired this cycle are not yet counted as free space, so the
  // stall decision depends only on registered state and this cycle's request.
  assign w_stall     = i_flush | i_stall_ext | (r_free_cnt < w_req_cnt);
  assign w_alloc_num = w_stall ? 2'd0 : i_req_num;

  // The pointers are exactly RRF_ENT_SEL bits wide, so the additions wrap
  // modulo RRF_ENT_NUM by truncation.
  assign w_com_ptr_next = r_com_ptr + {{(RRF_ENT_SEL-2){1'b0}}, i_com_num};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dp_ptr   <= '0;
      r_com_ptr  <= '0;
      r_free_cnt <= LP_ALL_FREE;
    end else if (i_flush) begin
      // Everything beyond the commit point is discarded, so allocation
      // restarts right after the entries that retire in this same cycle.
      r_com_ptr  <= w_com_ptr_next;
      r_dp_ptr   <= w_com_ptr_next;
      r_free_cnt <= LP_ALL_FREE;
    end else begin
      r_dp_ptr   <= r_dp_ptr + {{(RRF_ENT_SEL-2){1'b0}}, w_alloc_num};
      r_com_ptr  <= w_com_ptr_next;
      r_free_cnt <= r_free_cnt
                    - {{(RRF_ENT_SEL-1){1'b0}}, w_alloc_num}
                    + {{(RRF_ENT_SEL-1){1'b0}}, i_com_num};
    end
  end

  assign o_alloc_ptr_1 = r_dp_ptr;
  assign o_alloc_ptr_2 = r_dp_ptr + {{(RRF_ENT_SEL-1){1'b0}}, 1'b1};
  assign o_stall       = w_stall;
  assign o_com_ptr     = r_com_ptr;
  assign o_free_num    = r_free_cnt;
  assign o_full        = (r_free_cnt == '0);
  assign o_empty       = (r_free_cnt == LP_ALL_FREE);

endmodule

// File: tb/tb_rrf_freelist.sv
// ---------------------------------------------------------------------------
// tb_rrf_freelist
//   Directed bench for rrf_freelist. Each step drives one cycle of inputs.
//   A reference model computes the outputs expected for that cycle and
//   pushes them to a scoreboard queue. The entry is popped and compared
//   shortly after the inputs settle, and then the model advances to the
//   state expected after the rising edge.
// ---------------------------------------------------------------------------
module tb_rrf_freelist;

  localparam int N   = 64;
  localparam int SEL = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     i_req_num;
  logic           i_stall_ext;
  logic [1:0]     i_com_num;
  logic           i_flush;
  logic [SEL-1:0] o_alloc_ptr_1;
  logic [SEL-1:0] o_alloc_ptr_2;
  logic           o_stall;
  logic [SEL-1:0] o_com_ptr;
  logic [SEL:0]   o_free_num;
  logic           o_full;
  logic           o_empty;

  rrf_freelist #(.RRF_ENT_NUM(N), .RRF_ENT_SEL(SEL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_num    (i_req_num),
    .i_stall_ext  (i_stall_ext),
    .i_com_num    (i_com_num),
    .i_flush      (i_flush),
    .o_alloc_ptr_1(o_alloc_ptr_1),
    .o_alloc_ptr_2(o_alloc_ptr_2),
    .o_stall      (o_stall),
    .o_com_ptr    (o_com_ptr),
    .o_free_num   (o_free_num),
    .o_full       (o_full),
    .o_empty      (o_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a1;
    int a2;
    int st;
    int cp;
    int fn;
    int fu;
    int em;
  } exp_t;

  exp_t q_exp[$];

  int m_dp   = 0;
  int m_com  = 0;
  int m_free = N;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_err  = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (vector %0d)", tag, obs, expv, n_vec);
    end
  endtask

  // One cycle: drive inputs, queue expectation, compare, advance model.
  task automatic step(input int req, input bit ext, input int cn, input bit fl, input bit rst);
    exp_t e;
    exp_t g;
    int   st;
    int   an;
    @(negedge clk);
    if (req > 2 || cn > 2 || cn > (N - m_free)) begin
      n_err++;
      $error("FAIL illegal_stimulus: req %0d com %0d with free %0d", req, cn, m_free);
    end
    rst_n       = rst;
    i_req_num   = req[1:0];
    i_stall_ext = ext;
    i_com_num   = cn[1:0];
    i_flush     = fl;
    n_vec++;

    st   = (fl || ext || (m_free < req)) ? 1 : 0;
    e.a1 = m_dp;
    e.a2 = (m_dp + 1) % N;
    e.st = st;
    e.cp = m_com;
    e.fn = m_free;
    e.fu = (m_free == 0) ? 1 : 0;
    e.em = (m_free == N) ? 1 : 0;
    q_exp.push_back(e);

    #1;
    g = q_exp.pop_front();
    chk("alloc_ptr_1", int'(o_alloc_ptr_1), g.a1);
    chk("alloc_ptr_2", int'(o_alloc_ptr_2), g.a2);
    chk("stall",       int'(o_stall),       g.st);
    chk("com_ptr",     int'(o_com_ptr),     g.cp);
    chk("free_num",    int'(o_free_num),    g.fn);
    chk("full",        int'(o_full),        g.fu);
    chk("empty",       int'(o_empty),       g.em);
    $display("vec %0d: rst_n=%0d req=%0d ext=%0d com=%0d flush=%0d -> a1=%0d a2=%0d stall=%0d cp=%0d free=%0d",
             n_vec, rst, req, ext, cn, fl, o_alloc_ptr_1, o_alloc_ptr_2, o_stall, o_com_ptr, o_free_num);

    an = st ? 0 : req;
    if (!rst) begin
      m_dp = 0; m_com = 0; m_free = N;
    end else if (fl) begin
      m_com  = (m_com + cn) % N;
      m_dp   = m_com;
      m_free = N;
    end else begin
      m_dp   = (m_dp + an) % N;
      m_com  = (m_com + cn) % N;
      m_free = m_free - an + cn;
    end
  endtask

  initial begin
    rst_n = 1'b0; i_req_num = 2'd0; i_stall_ext = 1'b0; i_com_num = 2'd0; i_flush = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: stall follows the external stall only.
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Fill the whole list two entries at a time: 0/1, 2/3, ... 62/63.
    for (int i = 0; i < 32; i++) step(2, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);          // free 0, full
    step(2, 0, 0, 0, 1);          // request while full stalls

    // One free entry; a request of two stalls despite a same-cycle commit.
    step(0, 0, 1, 0, 1);
    step(2, 0, 2, 0, 1);
    step(0, 0, 0, 0, 1);          // free 3, dp unchanged

    // Retire up to entry 63, flush so dp lands on 63, then wrap.
    for (int i = 0; i < 30; i++) step(0, 0, 2, 0, 1);
    step(0, 0, 0, 1, 1);
    step(2, 0, 0, 0, 1);          // grants 63 and 0
    step(0, 0, 0, 0, 1);          // dp now 1

    // Build com_ptr=10, dp_ptr=20, exercising combined alloc+commit.
    step(0, 0, 2, 0, 1);          // com 1, list empty
    for (int i = 0; i < 9; i++) step(2, 0, 0, 0, 1);
    step(1, 0, 2, 0, 1);          // alloc and commit together
    for (int i = 0; i < 3; i++) step(0, 0, 2, 0, 1);
    step(0, 0, 1, 0, 1);
    step(2, 0, 1, 1, 1);          // flush with commit: stall, both ptrs to 11
    step(0, 0, 0, 0, 1);

    // External stall with an empty list leaves everything unchanged.
    step(2, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Bring free count to 5, then reset during a flush.
    for (int i = 0; i < 40 && m_free > 5; i++) step((m_free - 5 >= 2) ? 2 : 1, 0, 0, 0, 1);
    step(2, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);          // all reset values
    step(0, 1, 0, 0, 1);

    if (q_exp.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
